// File: rtl/ldpcenc_xacc.sv
// ldpcenc_xacc: per-row XOR accumulator placed after the 81-bit cyclic shifter.
// Accumulates shifted sub-blocks into lambda[0..MAXR-1], then drains
// lambda[0..nrows-1] in row order over a valid/ready handshake.
// Optional build macro LDPCENC_XACC_SUM_EN adds the registered sum_data output
// (XOR of all active rows, loaded on the last input beat).
module ldpcenc_xacc #(
  parameter int ZW   = 81,
  parameter int MAXR = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [ZW-1:0] in_data,
  input  logic [3:0]    in_row,
  input  logic          in_first,
  input  logic          in_last,
  input  logic [3:0]    nrows,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [ZW-1:0] out_data,
  output logic [3:0]    out_row,
  output logic          out_last,
  output logic          err
`ifdef LDPCENC_XACC_SUM_EN
  ,
  output logic [ZW-1:0] sum_data
`endif
);

  localparam logic [3:0] MAXR_L = 4'(MAXR);

  typedef enum logic {
    S_ACC   = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    nrows_q, nrows_d;
  logic          err_q, err_d;
  logic          need_first_q, need_first_d;
  logic [ZW-1:0] lambda_q [MAXR];
  logic [ZW-1:0] lambda_d [MAXR];

  logic          accept;
  logic          nrows_bad;
  logic [3:0]    nrows_eff;
  logic          row_ok;

  // Next-state: beat acceptance, bank update, error tracking and drain sequencing.
  always_comb begin : next_state
    // NOTE: every variable gets a default before any branch, so no path can leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    nrows_d      = nrows_q;
    err_d        = err_q;
    need_first_d = need_first_q;
    lambda_d     = lambda_q;

    accept    = (state_q == S_ACC) && in_vld;
    nrows_bad = (nrows == 4'd0) || (nrows > MAXR_L);
    // A first beat validates against the nrows it brings, not the stale one.
    nrows_eff = nrows_q;
    if (in_first) nrows_eff = nrows_bad ? MAXR_L : nrows;
    row_ok = (in_row < nrows_eff);

    if (accept) begin
      if (in_first) begin
        nrows_d = nrows_eff;
        if (nrows_bad) err_d = 1'b1;
      end
      if (need_first_q && !in_first) err_d = 1'b1;
      need_first_d = 1'b0;

      if (!row_ok) begin
        // Out-of-range row: drop the data, leave the bank untouched.
        err_d = 1'b1;
      end else begin
        for (int r = 0; r < MAXR; r++) begin
          if (in_first) begin
            lambda_d[r] = (in_row == 4'(r)) ? in_data : '0;
          end else if (in_row == 4'(r)) begin
            lambda_d[r] = lambda_q[r] ^ in_data;
          end
        end
      end

      if (in_last) begin
        state_d = S_DRAIN;
        cnt_d   = 4'd0;
      end
    end

    if (state_q == S_DRAIN && out_rdy) begin
      if (out_last) begin
        state_d      = S_ACC;
        cnt_d        = 4'd0;
        need_first_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // State, counters, flags and the lambda bank.
  always_ff @(posedge clk) begin : regs
    // NOTE: sequential state uses <= so every flop samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      state_q      <= S_ACC;
      cnt_q        <= 4'd0;
      nrows_q      <= MAXR_L;
      err_q        <= 1'b0;
      need_first_q <= 1'b1;
      // NOTE: the bank is built from flops, not a RAM macro, so clearing it in reset is legal and cheap.
      for (int r = 0; r < MAXR; r++) lambda_q[r] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nrows_q      <= nrows_d;
      err_q        <= err_d;
      need_first_q <= need_first_d;
      lambda_q     <= lambda_d;
    end
  end

  // Output select: row under the drain counter, decoded as a mux over the bank.
  always_comb begin : out_sel
    out_data = '0;
    for (int r = 0; r < MAXR; r++) begin
      if (cnt_q == 4'(r)) out_data = lambda_q[r];
    end
  end

  assign in_rdy   = (state_q == S_ACC);
  assign out_vld  = (state_q == S_DRAIN);
  assign out_row  = cnt_q;
  assign out_last = (state_q == S_DRAIN) && (cnt_q == nrows_q - 4'd1);
  assign err      = err_q;

`ifdef LDPCENC_XACC_SUM_EN
  logic [ZW-1:0] sum_q, sum_d;

  // Running parity seed: XOR of the updated active rows, captured with the last beat.
  always_comb begin : sum_next
    sum_d = sum_q;
    if (accept && in_last) begin
      sum_d = '0;
      for (int r = 0; r < MAXR; r++) begin
        if (4'(r) < nrows_eff) sum_d = sum_d ^ lambda_d[r];
      end
    end
  end

  // Sum register; holds through the drain until the next codeword ends.
  always_ff @(posedge clk) begin : sum_reg
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign sum_data = sum_q;
`endif

endmodule

// File: doc/ldpcenc_xacc.md
Name: ldpcenc_xacc

Overview:
- Per-row XOR accumulator directly downstream of the encoder's 81-bit right cyclic shifter.
- Consumes the shifted information sub-blocks, one beat per nonzero base-matrix entry, and XOR-accumulates them into per-row registers lambda[r].
- After the last contribution of a codeword, it drains lambda[0..nrows-1] in row order to the parity-computation stage over a valid/ready handshake.

Parameters:
- ZW, 81, sub-block width in bits. Unused MSBs for Z=27/54 arrive as zero and are passed through untouched.
- MAXR, 12, number of row accumulators. This is the maximum base-matrix rows, rate 1/2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_vld  input  1  input beat valid
- in_rdy  output  1  block can accept a beat
- in_data  input  ZW  shifted sub-block from the shifter
- in_row  input  4  target row index 0..MAXR-1
- in_first  input  1  first beat of a codeword; clears the whole bank
- in_last  input  1  last beat of a codeword
- nrows  input  4  rows in this code rate (12/8/6/4); sampled on a first beat
- out_vld  output  1  lambda output valid
- out_rdy  input  1  downstream accepts the output
- out_data  output  ZW  lambda[out_row]
- out_row  output  4  row index of out_data
- out_last  output  1  high with the final row of the drain
- err  output  1  sticky error flag

Behaviour:
- States: ACC and DRAIN. Reset enters ACC.
- Reset values: all lambda = 0, in_rdy = 1, out_vld = 0, out_row = 0, out_last = 0, err = 0, row counter = 0, latched nrows = 12.
- ACC state:
  - in_rdy = 1 and out_vld = 0.
  - A beat is accepted when in_vld & in_rdy.
  - Accepted beat with in_first = 0: lambda[in_row] <= lambda[in_row] ^ in_data; other rows hold.
  - Accepted beat with in_first = 1: lambda[in_row] <= in_data and all other rows <= 0 in the same cycle. nrows is latched on this beat.
  - in_first = 1 and in_last = 1 on the same beat is legal: a single-contribution codeword.
  - Accepted in_last: next state DRAIN, row counter <= 0.
- DRAIN state:
  - in_rdy = 0; input beats are stalled and not lost.
  - out_vld = 1, out_row = counter, out_data = lambda[counter].
  - out_last = (counter == latched nrows - 1).
  - On out_vld & out_rdy: counter increments. If out_last, next state is ACC and the counter clears.
  - out_rdy low holds out_data, out_row and out_last stable.
  - The lambda bank is not modified during DRAIN.
- Latency: last input beat accepted at cycle t gives out_vld = 1 at t+1. With out_rdy held high, the drain takes nrows cycles, and in_rdy returns at t+nrows+1.
- All outputs are driven from registers and state; there is no combinational path from in_* to out_*. Back-to-back codewords have no bubble beyond the drain.
- Error conditions (err set, cleared only by rst):
  - in_row >= latched nrows on an accepted beat: the beat is dropped, no lambda changes.
  - nrows == 0 or nrows > 12 on a first beat: latched nrows forced to 12.
  - The first accepted beat after reset or after a drain does not have in_first = 1: err is set, but the beat is still accumulated.
- Reset mid-operation, in either ACC or DRAIN: the bank is cleared, the state returns to ACC, and any partial drain is abandoned with no out_last.

Optional Feature:
- Macro: LDPCENC_XACC_SUM_EN.
- When defined, adds output port sum_data [ZW-1:0], registered.
  - On the in_last acceptance cycle it loads the XOR of all updated lambda[0..latched nrows-1], i.e. including the last beat.
  - It is valid while out_vld is high and holds until the next drain. Reset value is 0.
  - The parity stage uses it to form p0 without re-reading every row.
- When not defined, the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then nrows = 4. Beats:
  - (row0, 0x1, first)
  - (row0, 0x3)
  - (row2, 0xF0)
  - (row3, 0x5, last)
  - Required: out sequence 0x2, 0x0, 0xF0, 0x5 on rows 0..3, out_last only on row 3, out_vld one cycle after the last beat, err = 0. With SUM_EN: sum_data = 0xF7.
- Drain with out_rdy toggling 1,0,0,1,1,0,1: out_data and out_row stay stable while stalled, and exactly 4 transfers occur. in_vld held high during the drain is not accepted until the cycle after the row-3 transfer.
- Back-to-back codewords, nrows = 12 then 6: the second codeword's first beat clears all stale rows. The second drain is exactly 6 rows, every unaddressed row reads 0.
- Beat with in_row = 9 while nrows = 8: the beat is dropped, err = 1 and stays 1 through the following codewords, other rows are unaffected.
- nrows = 13 on the first beat: err = 1, the drain is 12 rows.
- Assert rst during DRAIN after 2 rows transferred: the next cycle has out_vld = 0, in_rdy = 1, err = 0. A new first+last beat (row1, 0xABC) with nrows = 4 drains 0, 0xABC, 0, 0.
